spi_flash_read_cache: RTL
=========================

// Module: spi_flash_read_cache
// PURPOSE
//  Direct-mapped, read-only word cache between the CPU data/instruction port and MappedSPIFlash.
//  Hits return in one cycle with no busy; misses run one 0x03 flash read and fill the line.
//  Keeps code executing from SPI flash from paying the ~70-cycle serial read on every fetch.
// PARAMETERS
//  INDEX_BITS  6   log2(number of one-word lines); 64 lines
//  ADDR_BITS   20  word address width, equal to MappedSPIFlash word_address
//  (tag width TAG_BITS = ADDR_BITS-INDEX_BITS)
// PORTS
//  clk                 in  1          system clock, all logic on posedge
//  reset               in  1          synchronous, active-high
//  cpu_rstrb           in  1          one-cycle read request
//  cpu_word_address    in  ADDR_BITS  word address, sampled with cpu_rstrb
//  cpu_rdata           out 32         read data, registered
//  cpu_rbusy           out 1          high while a miss is outstanding
//  invalidate          in  1          one-cycle pulse: clear all valid bits
//  flash_rstrb         out 1          read strobe to MappedSPIFlash
//  flash_word_address  out ADDR_BITS  address to MappedSPIFlash
//  flash_rdata         in  32         MappedSPIFlash rdata, already byte-swizzled
//  flash_rbusy         in  1          MappedSPIFlash rbusy (high while CS_N low)
// BEHAVIOUR
//  - Single clock domain. Reset is synchronous and active-high.
//  - Reset values: cpu_rdata=0, cpu_rbusy=0, flash_rstrb=0, flash_word_address=0.
//    All valid bits are 0 and the state is IDLE. Tag/data arrays are not reset.
//  - Address split: index=addr[INDEX_BITS-1:0], tag=addr[ADDR_BITS-1:INDEX_BITS].
//  - FSM states: IDLE, ISSUE, WAIT.
//    IDLE, cpu_rstrb=1, hit:
//      cpu_rdata <= data[index]; stay in IDLE; cpu_rbusy stays 0.
//      Data is valid in the cycle after the strobe.
//    IDLE, cpu_rstrb=1, miss:
//      latch address; cpu_rbusy <= 1; go to ISSUE.
//    ISSUE:
//      flash_rstrb = (state==ISSUE && !flash_rbusy); this is combinational, one cycle.
//      flash_word_address = latched address.
//      Go to WAIT on the edge where flash_rstrb=1. While flash_rbusy=1, hold in ISSUE.
//      This drains a transfer left over from a reset.
//    WAIT:
//      flash_rbusy rises the cycle after the strobe.
//      When flash_rbusy=0: data[index] <= flash_rdata, tag <= tag, valid <= 1.
//      Same edge: cpu_rdata <= flash_rdata, cpu_rbusy <= 0, go to IDLE.
//  - Miss latency: cpu_rbusy is high from cycle+1 after the strobe through the fill edge.
//    That is flash busy time + 2 cycles. Data is valid in the first cycle cpu_rbusy=0.
//  - cpu_rstrb while cpu_rbusy=1 is ignored; the CPU must not issue it.
//    cpu_rdata holds its value between reads.
//  - invalidate: all valid <= 0 at that edge.
//    invalidate together with cpu_rstrb: the access is a miss.
//    invalidate during WAIT: the pending fill still writes and sets its own line valid,
//    which is acceptable for read-only flash.
//  - Conflict: a miss overwrites the line unconditionally. No write path; flash is read-only here.
//  - reset mid-miss: state -> IDLE, cpu_rbusy -> 0, valid cleared, fill discarded.
//    The flash finishes on its own. The next miss waits in ISSUE until flash_rbusy=0.
//  - Address 2^ADDR_BITS-1 (max index and tag) needs no special casing; there is no wrap logic.
// TESTING
//  1. After reset, read 0x00010 with flash model returning 0xDEADBEEF:
//     cpu_rbusy=1 until fill, cpu_rdata=0xDEADBEEF, exactly 1 flash_rstrb.
//  2. Read 0x00010 again: cpu_rdata=0xDEADBEEF next cycle, cpu_rbusy stays 0, no flash_rstrb.
//  3. Read 0x00050 (same index 0x10, tag 1): miss, flash read of 0x00050.
//     A then-repeated read of 0x00010 misses again.
//  4. Pulse invalidate, then read 0x00050: miss with 1 flash_rstrb.
//     Repeat with invalidate and cpu_rstrb in the same cycle: also a miss.
//  5. Assert reset mid-WAIT (flash_rbusy=1), then strobe 0x00020 immediately:
//     no flash_rstrb while flash_rbusy=1, one strobe after it falls, correct data returned.
//  6. Back-to-back hit strobes to 0x00010 and 0x00050 on consecutive cycles after both are filled:
//     cpu_rdata updates each cycle with the matching values.

Source files
------------

// File: rtl/spi_flash_read_cache.sv
// Direct-mapped, read-only, one-word-per-line cache in front of MappedSPIFlash.
// Hits answer in one cycle; misses issue a single flash read and fill the line.
module spi_flash_read_cache #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned ADDR_BITS  = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_rstrb,
  input  logic [ADDR_BITS-1:0] cpu_word_address,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_rbusy,
  input  logic                 invalidate,
  output logic                 flash_rstrb,
  output logic [ADDR_BITS-1:0] flash_word_address,
  input  logic [31:0]          flash_rdata,
  input  logic                 flash_rbusy
);

  localparam int unsigned TAG_BITS = ADDR_BITS - INDEX_BITS;
  localparam int unsigned LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [31:0]           rdata_q;
  logic                  rbusy_q;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic [INDEX_BITS-1:0] cpu_idx, fill_idx;
  logic [TAG_BITS-1:0]   cpu_tag, fill_tag;
  logic                  hit, hit_rd, miss_start, fill;

  assign cpu_idx  = cpu_word_address[INDEX_BITS-1:0];
  assign cpu_tag  = cpu_word_address[ADDR_BITS-1:INDEX_BITS];
  assign fill_idx = addr_q[INDEX_BITS-1:0];
  assign fill_tag = addr_q[ADDR_BITS-1:INDEX_BITS];

  // An invalidate in the same cycle as a strobe forces that access to miss.
  assign hit = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag) && !invalidate;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_rstrb && !hit) state_d = ISSUE;
      ISSUE:   if (!flash_rbusy)      state_d = WAIT;
      WAIT:    if (!flash_rbusy)      state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // ISSUE holds off while flash is still busy with a transfer orphaned by reset.
  always_comb begin
    flash_rstrb = 1'b0;
    hit_rd      = 1'b0;
    miss_start  = 1'b0;
    fill        = 1'b0;
    case (state_q)
      IDLE: begin
        hit_rd     = cpu_rstrb && hit;
        miss_start = cpu_rstrb && !hit;
      end
      ISSUE:   flash_rstrb = !flash_rbusy;
      WAIT:    fill        = !flash_rbusy;
      default: ;
    endcase
  end

  // A fill racing an invalidate still marks its own line valid.
  always_comb begin
    valid_d = invalidate ? '0 : valid_q;
    if (fill) valid_d[fill_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      rdata_q <= '0;
      rbusy_q <= 1'b0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (miss_start) begin
        addr_q  <= cpu_word_address;
        rbusy_q <= 1'b1;
      end
      if (hit_rd) rdata_q <= data_mem[cpu_idx];
      if (fill) begin
        rdata_q <= flash_rdata;
        rbusy_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill && !reset) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= flash_rdata;
    end
  end

  assign cpu_rdata          = rdata_q;
  assign cpu_rbusy          = rbusy_q;
  assign flash_word_address = addr_q;

endmodule
